// File: rtl/sipo_frame_pkg.sv
// Shared types and helpers for the SIPO frame sequencer.
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter width that never collapses to zero bits when n == 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register: din enters the MSB and moves toward the LSB.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch, not the sensitivity list.
    if (rst) begin
      q <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignment so every flop updates from pre-edge values.
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer: paces WIDTH serial samples at one per DIV clocks, then offers the
// assembled word on a single-entry valid/ready output buffer with a sticky overrun flag.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sdata,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int DW = cnt_w(DIV);
  localparam int BW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;

  logic             bit_tick;
  logic             last_bit;
  logic             buf_free;
  logic             shift_en;
  logic             load;
  logic             set_ovr;
  logic [WIDTH-1:0] sr_q;

  assign bit_tick = (div_cnt_q == DW'(DIV - 1));
  assign last_bit = (bit_cnt_q == BW'(WIDTH - 1));
  // The buffer can take a new word if empty or being drained in this same cycle.
  assign buf_free = !dout_valid_q || dout_ready;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clk (clk),
    .rst (rst),
    .en  (shift_en),
    .din (sdata),
    .q   (sr_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT: begin
        if (abort)                     state_d = IDLE;
        else if (bit_tick && last_bit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; abort suppresses both the shift and the DONE load/overrun.
  always_comb begin
    busy     = (state_q != IDLE);
    shift_en = (state_q == SHIFT) && !abort && bit_tick;
    load     = (state_q == DONE) && !abort && buf_free;
    set_ovr  = (state_q == DONE) && !abort && !buf_free;
  end

  // Bit pacing counters
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (state_q == IDLE) begin
      if (start) begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
      end
    end else if (state_q == SHIFT) begin
      div_cnt_d = bit_tick ? '0 : div_cnt_q + DW'(1);
      if (shift_en) bit_cnt_d = bit_cnt_q + BW'(1);
    end
  end

  // Output buffer and overrun; a DONE load overrides the drain in the same cycle.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
    if (load) begin
      dout_d       = sr_q;
      dout_valid_d = 1'b1;
    end
    if (set_ovr)      overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
    else              overrun_d = overrun_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule
